// File: rtl/pdp8_sram_pkg.sv
// Shared types and sizes for the PDP-8 external SRAM arbiter.
// Holds the sequencer state enum, requester IDs and bus widths.
package pdp8_sram_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;
  localparam int PDP8_AW = 15;
  localparam int PDP8_DW = 12;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_HOLD   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_e;

endpackage

// File: rtl/pdp8_sram_arb_if.sv
// Asynchronous SRAM pin bundle (ram1 bank plus ram2 chip enable).
// master: arbiter drives address/strobes/data; slave: pad side.
interface pdp8_sram_arb_if;
  import pdp8_sram_pkg::*;

  logic [SRAM_AW-1:0] ram_a;
  logic               ram_oe_n;
  logic               ram_we_n;
  logic               ram1_ce_n;
  logic               ram1_ub_n;
  logic               ram1_lb_n;
  logic               ram2_ce_n;
  logic [SRAM_DW-1:0] ram_io_out;
  logic               ram_io_oe;
  logic [SRAM_DW-1:0] ram_io_in;

  modport master (
    output ram_a, ram_oe_n, ram_we_n,
    output ram1_ce_n, ram1_ub_n, ram1_lb_n,
    output ram2_ce_n, ram_io_out, ram_io_oe,
    input  ram_io_in
  );

  modport slave (
    input  ram_a, ram_oe_n, ram_we_n,
    input  ram1_ce_n, ram1_ub_n, ram1_lb_n,
    input  ram2_ce_n, ram_io_out, ram_io_oe,
    output ram_io_in
  );

endinterface

// File: rtl/pdp8_rr_arb2.sv
// Two-way round-robin grant between CPU and DMA requesters.
// Ports: req_cpu/req_dma, en (grant allowed), valid/gnt out.
module pdp8_rr_arb2
  import pdp8_sram_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  req_cpu,
  input  logic  req_dma,
  input  logic  en,
  output logic  valid,
  output port_e gnt
);

  port_e last_q;

  always_comb begin
    valid = en & (req_cpu | req_dma);
    gnt   = PORT_CPU;
    unique case (1'b1)
      req_cpu & req_dma:
        gnt = (last_q == PORT_DMA) ? PORT_CPU : PORT_DMA;
      req_dma & ~req_cpu:
        gnt = PORT_DMA;
      default:
        gnt = PORT_CPU;
    endcase
  end

  // Reset to DMA so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= PORT_DMA;
    end else if (valid) begin
      last_q <= gnt;
    end
  end

endmodule

// File: rtl/pdp8_sram_arb.sv
// CPU/DMA arbiter and setup/strobe/hold sequencer for external SRAM.
// Ports: clk/reset, CPU and DMA request ports, ram SRAM bundle.
module pdp8_sram_arb
  import pdp8_sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
)
(
  input  logic               clk,
  input  logic               reset,
  input  logic [PDP8_AW-1:0] cpu_addr,
  input  logic [PDP8_DW-1:0] cpu_data_in,
  input  logic               cpu_rd,
  input  logic               cpu_wr,
  output logic [PDP8_DW-1:0] cpu_data_out,
  output logic               cpu_done,
  input  logic [PDP8_AW-1:0] dma_ma,
  input  logic [PDP8_DW-1:0] dma_in,
  input  logic               dma_read_req,
  input  logic               dma_write_req,
  output logic [PDP8_DW-1:0] dma_out,
  output logic               dma_done,
  pdp8_sram_arb_if.master    ram
);

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_e     state_q, state_n;
  logic [3:0] cnt_q, cnt_n;
  logic       wr_q, wr_n;
  port_e      port_q, port_n;
  logic       grant;
  logic       arb_valid;
  port_e      arb_gnt;
  logic       busy_n, acc_n, cap;
  logic       unused_io;

  assign unused_io = ^ram.ram_io_in[SRAM_DW-1:PDP8_DW];

  pdp8_rr_arb2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req_cpu (cpu_rd | cpu_wr),
    .req_dma (dma_read_req | dma_write_req),
    .en      (state_q == S_IDLE),
    .valid   (arb_valid),
    .gnt     (arb_gnt)
  );

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    grant   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          state_n = S_SETUP;
          grant   = 1'b1;
        end
      end
      S_SETUP: begin
        state_n = S_ACCESS;
        cnt_n   = '0;
      end
      S_ACCESS: begin
        if (cnt_q == LAST) state_n = S_HOLD;
        else cnt_n = cnt_q + 4'd1;
      end
      S_HOLD:  state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Direction and owner take effect on the grant edge so the
  // SETUP-cycle outputs already reflect the new access.
  always_comb begin
    port_n = grant ? arb_gnt : port_q;
    wr_n   = wr_q;
    if (grant) begin
      wr_n = (arb_gnt == PORT_CPU) ? cpu_wr : dma_write_req;
    end
  end

  assign busy_n = (state_n == S_SETUP) ||
                  (state_n == S_ACCESS) ||
                  (state_n == S_HOLD);
  assign acc_n  = (state_n == S_ACCESS);
  assign cap    = (state_q == S_ACCESS) &&
                  (cnt_q == LAST) && !wr_q;

  assign ram.ram2_ce_n = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      wr_q           <= 1'b0;
      port_q         <= PORT_CPU;
      ram.ram_a      <= '0;
      ram.ram_io_out <= '0;
      ram.ram_io_oe  <= 1'b0;
      ram.ram_oe_n   <= 1'b1;
      ram.ram_we_n   <= 1'b1;
      ram.ram1_ce_n  <= 1'b1;
      ram.ram1_ub_n  <= 1'b1;
      ram.ram1_lb_n  <= 1'b1;
      cpu_done       <= 1'b0;
      dma_done       <= 1'b0;
      cpu_data_out   <= '0;
      dma_out        <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      wr_q    <= wr_n;
      port_q  <= port_n;
      if (grant) begin
        if (arb_gnt == PORT_CPU) begin
          ram.ram_a      <= {3'b000, cpu_addr};
          ram.ram_io_out <= {4'b0000, cpu_data_in};
        end else begin
          ram.ram_a      <= {3'b000, dma_ma};
          ram.ram_io_out <= {4'b0000, dma_in};
        end
      end
      ram.ram1_ce_n <= !busy_n;
      ram.ram1_ub_n <= !busy_n;
      ram.ram1_lb_n <= !busy_n;
      ram.ram_io_oe <= busy_n && wr_n;
      ram.ram_oe_n  <= !(acc_n && !wr_n);
      ram.ram_we_n  <= !(acc_n && wr_n);
      cpu_done <= (state_n == S_DONE) &&
                  (port_n == PORT_CPU);
      dma_done <= (state_n == S_DONE) &&
                  (port_n == PORT_DMA);
      if (cap) begin
        if (port_q == PORT_CPU)
          cpu_data_out <= ram.ram_io_in[PDP8_DW-1:0];
        else
          dma_out <= ram.ram_io_in[PDP8_DW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_pdp8_sram_arb.sv
// Scoreboard bench for pdp8_sram_arb: W=1 and W=3 instances.
// Strobe/done events are popped against queued expectations.
module tb_pdp8_sram_arb;
  import pdp8_sram_pkg::*;

  typedef struct {
    int          kind;
    int          cyc;
    logic [17:0] a;
    logic [15:0] dat;
  } ev_t;

  localparam int K_CDONE = 0;
  localparam int K_DDONE = 1;
  localparam int K_WE    = 2;
  localparam int K_OE    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared;
  int failed;

  logic        rst      [2];
  logic [14:0] cpu_addr [2];
  logic [11:0] cpu_din  [2];
  logic        cpu_rd   [2];
  logic        cpu_wr   [2];
  logic [11:0] cdout    [2];
  logic        cdone    [2];
  logic [14:0] dma_ma   [2];
  logic [11:0] dma_in   [2];
  logic        dma_rd   [2];
  logic        dma_wr   [2];
  logic [11:0] ddout    [2];
  logic        ddone    [2];

  pdp8_sram_arb_if sif0 ();
  pdp8_sram_arb_if sif1 ();

  pdp8_sram_arb #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(rst[0]),
    .cpu_addr(cpu_addr[0]), .cpu_data_in(cpu_din[0]),
    .cpu_rd(cpu_rd[0]), .cpu_wr(cpu_wr[0]),
    .cpu_data_out(cdout[0]), .cpu_done(cdone[0]),
    .dma_ma(dma_ma[0]), .dma_in(dma_in[0]),
    .dma_read_req(dma_rd[0]), .dma_write_req(dma_wr[0]),
    .dma_out(ddout[0]), .dma_done(ddone[0]),
    .ram(sif0)
  );

  pdp8_sram_arb #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(rst[1]),
    .cpu_addr(cpu_addr[1]), .cpu_data_in(cpu_din[1]),
    .cpu_rd(cpu_rd[1]), .cpu_wr(cpu_wr[1]),
    .cpu_data_out(cdout[1]), .cpu_done(cdone[1]),
    .dma_ma(dma_ma[1]), .dma_in(dma_in[1]),
    .dma_read_req(dma_rd[1]), .dma_write_req(dma_wr[1]),
    .dma_out(ddout[1]), .dma_done(ddone[1]),
    .ram(sif1)
  );

  logic [17:0] ra   [2];
  logic [15:0] rio  [2];
  logic        roe  [2];
  logic        rwe  [2];
  logic        rce  [2];
  logic        rub  [2];
  logic        rlb  [2];
  logic        rce2 [2];
  logic        rdrv [2];

  assign ra[0]   = sif0.ram_a;      assign ra[1]   = sif1.ram_a;
  assign rio[0]  = sif0.ram_io_out; assign rio[1]  = sif1.ram_io_out;
  assign roe[0]  = sif0.ram_oe_n;   assign roe[1]  = sif1.ram_oe_n;
  assign rwe[0]  = sif0.ram_we_n;   assign rwe[1]  = sif1.ram_we_n;
  assign rce[0]  = sif0.ram1_ce_n;  assign rce[1]  = sif1.ram1_ce_n;
  assign rub[0]  = sif0.ram1_ub_n;  assign rub[1]  = sif1.ram1_ub_n;
  assign rlb[0]  = sif0.ram1_lb_n;  assign rlb[1]  = sif1.ram1_lb_n;
  assign rce2[0] = sif0.ram2_ce_n;  assign rce2[1] = sif1.ram2_ce_n;
  assign rdrv[0] = sif0.ram_io_oe;  assign rdrv[1] = sif1.ram_io_oe;

  // SRAM models: async read while CE and OE low, write on WE low.
  logic [15:0] mem0 [1024];
  logic [15:0] mem1 [1024];
  logic        minit;

  assign sif0.ram_io_in = (!sif0.ram1_ce_n && !sif0.ram_oe_n) ?
                          mem0[sif0.ram_a[9:0]] : 16'h0000;
  assign sif1.ram_io_in = (!sif1.ram1_ce_n && !sif1.ram_oe_n) ?
                          mem1[sif1.ram_a[9:0]] : 16'h0000;

  always @(posedge clk) begin
    if (minit) begin
      for (int i = 0; i < 1024; i++) begin
        mem0[i] <= 16'h0000;
        mem1[i] <= 16'h0000;
      end
      mem0[10'h080] <= 16'hFABC;
      mem1[10'h080] <= 16'hFABC;
    end else begin
      if (!sif0.ram1_ce_n && !sif0.ram_we_n)
        mem0[sif0.ram_a[9:0]] <= sif0.ram_io_out;
      if (!sif1.ram1_ce_n && !sif1.ram_we_n)
        mem1[sif1.ram_a[9:0]] <= sif1.ram_io_out;
    end
  end

  ev_t q0 [$];
  ev_t q1 [$];

  task automatic push(input int d, input int kind, input int c,
                      input logic [17:0] a, input logic [15:0] dat);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.a    = a;
    e.dat  = dat;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic observe(input int d, input int kind,
                         input logic [17:0] a, input logic [15:0] dat);
    ev_t e;
    int  n;
    n = (d == 0) ? q0.size() : q1.size();
    compared++;
    if (n == 0) begin
      failed++;
      $display("FAIL dut%0d unexpected_event kind=%0d cyc=%0d a=%h d=%h, required none",
               d, kind, cyc, a, dat);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else e = q1.pop_front();
    if (e.kind != kind || e.cyc != cyc || e.a != a || e.dat != dat) begin
      failed++;
      $display("FAIL dut%0d event got kind=%0d cyc=%0d a=%h d=%h, required kind=%0d cyc=%0d a=%h d=%h",
               d, kind, cyc, a, dat, e.kind, e.cyc, e.a, e.dat);
    end
  endtask

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic monitor_step();
    for (int d = 0; d < 2; d++) begin
      compared++;
      if ((!roe[d] && !rwe[d]) || (rdrv[d] && !roe[d]) ||
          (cdone[d] && ddone[d]) || !rce2[d]) begin
        failed++;
        $display("FAIL dut%0d strobe_safety cyc=%0d oe_n=%b we_n=%b io_oe=%b dones=%b%b ce2_n=%b, required exclusive",
                 d, cyc, roe[d], rwe[d], rdrv[d], cdone[d], ddone[d], rce2[d]);
      end
      if (!rwe[d]) observe(d, K_WE, ra[d], rio[d]);
      if (!roe[d]) observe(d, K_OE, ra[d], 16'h0000);
      if (cdone[d]) observe(d, K_CDONE, 18'h0, {4'h0, cdout[d]});
      if (ddone[d]) observe(d, K_DDONE, 18'h0, {4'h0, ddout[d]});
    end
  endtask

  // One access on DUT d, issued in an IDLE cycle at a negedge.
  task automatic do_access(input int d, input bit dma, input bit wr,
                           input bit rdl, input logic [14:0] a,
                           input logic [11:0] wd,
                           input logic [11:0] exp_out);
    int c;
    int w;
    bit seen;
    c = cyc;
    w = (d == 0) ? 1 : 3;
    if (dma) begin
      dma_ma[d] = a; dma_in[d] = wd;
      dma_wr[d] = wr; dma_rd[d] = rdl;
    end else begin
      cpu_addr[d] = a; cpu_din[d] = wd;
      cpu_wr[d] = wr; cpu_rd[d] = rdl;
    end
    for (int k = 0; k < w; k++)
      push(d, wr ? K_WE : K_OE, c + 2 + k, {3'b000, a},
           wr ? {4'h0, wd} : 16'h0000);
    push(d, dma ? K_DDONE : K_CDONE, c + 3 + w, 18'h0, {4'h0, exp_out});
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (dma ? ddone[d] : cdone[d]) seen = 1'b1;
    end
    cpu_rd[d] = 1'b0; cpu_wr[d] = 1'b0;
    dma_rd[d] = 1'b0; dma_wr[d] = 1'b0;
    compared++;
    if (!seen) begin
      failed++;
      $display("FAIL dut%0d access_timeout got no done, required done at cyc %0d",
               d, c + 3 + w);
    end
    @(negedge clk);
  endtask

  task automatic stimulus();
    int c;
    int n;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset_values dut%0d", d),
          {29'h0, ra[d], rio[d], rdrv[d], roe[d], rwe[d], rce[d],
           rub[d], rlb[d], rce2[d], cdone[d], ddone[d],
           cdout[d], ddout[d]},
          {29'h0, 18'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1,
           1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0, 12'h0});
    rst[0] = 1'b0; rst[1] = 1'b0; minit = 1'b0;
    @(negedge clk);

    // W=1: read 0o200, write 0o7402 there, DMA read+write.
    do_access(0, 0, 0, 1, 15'o00200, 12'h000, 12'hABC);
    do_access(0, 0, 1, 0, 15'o00200, 12'o7402, 12'hABC);
    do_access(0, 1, 1, 1, 15'o00300, 12'o5555, 12'h000);

    // Six-access tie: CPU writes 0o100, DMA reads it back.
    c = cyc;
    cpu_addr[0] = 15'o00100; cpu_din[0] = 12'o1234; cpu_wr[0] = 1'b1;
    dma_ma[0] = 15'o00100; dma_rd[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        push(0, K_WE, c + 5 * i + 2, 18'h00040, 16'h029C);
        push(0, K_CDONE, c + 5 * i + 4, 18'h0, 16'h0ABC);
      end else begin
        push(0, K_OE, c + 5 * i + 2, 18'h00040, 16'h0000);
        push(0, K_DDONE, c + 5 * i + 4, 18'h0, 16'h029C);
      end
    end
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(negedge clk);
      if (ddone[0]) n++;
    end
    cpu_wr[0] = 1'b0; dma_rd[0] = 1'b0;
    chk("tie_dma_done_count", 96'(n), 96'd3);
    @(negedge clk);

    do_access(0, 0, 0, 1, 15'o00200, 12'h000, 12'hF02);

    // Reset during ACCESS of a DMA write.
    c = cyc;
    dma_ma[0] = 15'h0010; dma_in[0] = 12'h123; dma_wr[0] = 1'b1;
    push(0, K_WE, c + 2, 18'h00010, 16'h0123);
    repeat (2) @(negedge clk);
    rst[0] = 1'b1; dma_wr[0] = 1'b0;
    @(negedge clk);
    chk("reset_mid_access",
        {88'h0, roe[0], rwe[0], rce[0], rub[0], rlb[0],
         rdrv[0], cdone[0], ddone[0]},
        {88'h0, 8'b1111_1000});
    rst[0] = 1'b0;
    @(negedge clk);
    do_access(0, 0, 0, 1, 15'o00300, 12'h000, 12'hB6D);

    // W=3: read, write, read back.
    do_access(1, 0, 0, 1, 15'o00200, 12'h000, 12'hABC);
    do_access(1, 1, 1, 0, 15'h0005, 12'h777, 12'h000);
    do_access(1, 1, 0, 1, 15'h0005, 12'h000, 12'h777);

    repeat (5) @(negedge clk);
    chk("cpu_out_held_w1", {84'h0, cdout[0]}, {84'h0, 12'hB6D});
    chk("dma_out_after_reset", {84'h0, ddout[0]}, 96'h0);
    chk("cpu_out_held_w3", {84'h0, cdout[1]}, {84'h0, 12'hABC});
    chk("dma_out_w3", {84'h0, ddout[1]}, {84'h0, 12'h777});
    chk("queue0_drained", 96'(q0.size()), 96'd0);
    chk("queue1_drained", 96'(q1.size()), 96'd0);
  endtask

  initial begin
    compared = 0;
    failed   = 0;
    minit    = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      cpu_addr[d] = '0; cpu_din[d] = '0;
      cpu_rd[d] = 1'b0; cpu_wr[d] = 1'b0;
      dma_ma[d] = '0; dma_in[d] = '0;
      dma_rd[d] = 1'b0; dma_wr[d] = 1'b0;
    end
    fork
      begin
        forever begin
          @(negedge clk);
          monitor_step();
        end
      end
      begin
        stimulus();
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, failed);
    $finish;
  end

endmodule
